// File: rtl/bcd2_count_mux_if.sv
//------------------------------------------------------------------------------
// Module      : bcd2_count_mux_if
// Description : Control/status bundle for the two-digit BCD counter with
//               multiplexed 7-segment display feed.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd2_count_mux_if;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       wrap;
  logic [3:0] digit_data;
  logic [1:0] digit_sel;

  // Controller side: drives count controls, observes digits and display feed
  modport master (
    output en, up, load, load_val,
    input  tens, ones, wrap, digit_data, digit_sel
  );

  // Counter side
  modport slave (
    input  en, up, load, load_val,
    output tens, ones, wrap, digit_data, digit_sel
  );
endinterface

`default_nettype wire

// File: rtl/bcd2_count_mux.sv
//------------------------------------------------------------------------------
// Module      : bcd2_count_mux
// Description : Two-digit BCD up/down counter (00-99) with step prescaler,
//               parallel load, wrap pulse and a time-multiplexed digit feed
//               (one BCD digit + one-hot select) for a 7-segment decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd2_count_mux #(
  parameter int TICK_DIV    = 50000000,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 0
) (
  input  wire                     clk,
  input  wire                     rst,
  bcd2_count_mux_if.slave         bus
);

  // A divider of 1 still needs a 1-bit counter that simply stays at 0
  localparam int TICK_W = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [TICK_W-1:0] c_TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [REF_W-1:0]  c_REF_MAX  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_t;

  logic [TICK_W-1:0] r_tick_cnt;
  logic [REF_W-1:0]  r_ref_cnt;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic              r_wrap;
  slot_t             r_slot;
  slot_t             w_slot_nxt;

  logic              w_step;
  logic              w_ref_done;
  logic [3:0]        w_tens_step;
  logic [3:0]        w_ones_step;
  logic              w_wrap_step;
  logic [3:0]        w_digit_data;
  logic [1:0]        w_digit_sel;

  // Load nibbles above 9 saturate so the digits can never leave 0-9
  function automatic logic [3:0] f_clamp(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign w_step     = bus.en && (r_tick_cnt == c_TICK_MAX);
  assign w_ref_done = (r_ref_cnt == c_REF_MAX);

  // Next digit values for one count step in the sampled direction
  always_comb begin
    w_tens_step = r_tens;
    w_ones_step = r_ones;
    w_wrap_step = 1'b0;
    if (bus.up) begin
      if (r_ones >= 4'd9) begin
        w_ones_step = 4'd0;
        if (r_tens >= 4'd9) begin
          w_tens_step = 4'd0;
          w_wrap_step = 1'b1;
        end else begin
          w_tens_step = r_tens + 4'd1;
        end
      end else begin
        w_ones_step = r_ones + 4'd1;
      end
    end else begin
      if (r_ones == 4'd0) begin
        w_ones_step = 4'd9;
        if (r_tens == 4'd0) begin
          w_tens_step = 4'd9;
          w_wrap_step = 1'b1;
        end else begin
          w_tens_step = r_tens - 4'd1;
        end
      end else begin
        w_ones_step = r_ones - 4'd1;
      end
    end
  end

  // Step prescaler and digit registers; load beats a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_wrap     <= 1'b0;
    end else if (bus.load) begin
      r_tick_cnt <= '0;
      r_tens     <= f_clamp(bus.load_val[7:4]);
      r_ones     <= f_clamp(bus.load_val[3:0]);
      r_wrap     <= 1'b0;
    end else if (bus.en) begin
      if (w_step) begin
        r_tick_cnt <= '0;
        r_tens     <= w_tens_step;
        r_ones     <= w_ones_step;
        r_wrap     <= w_wrap_step;
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        r_wrap     <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Free-running refresh prescaler; unaffected by enable or load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= '0;
    end else if (w_ref_done) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // Scan slot state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= SLOT_ONES;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  // Scan slot toggles at the end of each refresh period
  always_comb begin
    w_slot_nxt = r_slot;
    if (w_ref_done) begin
      w_slot_nxt = (r_slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end
  end

  // Display feed is purely combinational from registered state
  always_comb begin
    w_digit_data = r_ones;
    w_digit_sel  = 2'b01;
    if (r_slot == SLOT_TENS) begin
      if ((BLANK_LZ != 0) && (r_tens == 4'd0)) begin
        w_digit_data = 4'd0;
        w_digit_sel  = 2'b00;
      end else begin
        w_digit_data = r_tens;
        w_digit_sel  = 2'b10;
      end
    end
  end

  assign bus.tens       = r_tens;
  assign bus.ones       = r_ones;
  assign bus.wrap       = r_wrap;
  assign bus.digit_data = w_digit_data;
  assign bus.digit_sel  = w_digit_sel;

endmodule

`default_nettype wire

// File: tb/tb_bcd2_count_mux.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd2_count_mux
// Description : Self-checking bench for bcd2_count_mux (two instances, without
//               and with leading-zero blanking, sharing the same stimulus).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd2_count_mux;

  localparam int TICK_DIV    = 4;
  localparam int REFRESH_DIV = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] lv;
    int         ncyc;
    logic [7:0] exp_val;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[22];

  always #5 clk = ~clk;

  bcd2_count_mux_if u_if0 ();
  bcd2_count_mux_if u_if1 ();

  assign u_if0.en       = en;
  assign u_if0.up       = up;
  assign u_if0.load     = load;
  assign u_if0.load_val = load_val;
  assign u_if1.en       = en;
  assign u_if1.up       = up;
  assign u_if1.load     = load;
  assign u_if1.load_val = load_val;

  bcd2_count_mux #(
    .TICK_DIV    (TICK_DIV),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_LZ    (0)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0.slave)
  );

  bcd2_count_mux #(
    .TICK_DIV    (TICK_DIV),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_LZ    (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.slave)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] ev, input logic ew);
    n_cmp++;
    if ({u_if0.tens, u_if0.ones, u_if0.wrap} !== {ev, ew}) begin
      n_bad++;
      $display("FAIL %s (nolz): got %h%h wrap=%b, required %h wrap=%b",
               name, u_if0.tens, u_if0.ones, u_if0.wrap, ev, ew);
    end
    n_cmp++;
    if ({u_if1.tens, u_if1.ones, u_if1.wrap} !== {ev, ew}) begin
      n_bad++;
      $display("FAIL %s (blz): got %h%h wrap=%b, required %h wrap=%b",
               name, u_if1.tens, u_if1.ones, u_if1.wrap, ev, ew);
    end
  endtask

  // k = clock edges since the reset edge; each slot lasts REFRESH_DIV edges
  task automatic check_scan(input string name, input int k, input logic [7:0] val);
    logic       tens_slot;
    logic [1:0] s0, s1;
    logic [3:0] d0, d1;
    tens_slot = (((k / REFRESH_DIV) % 2) == 1);
    if (tens_slot) begin
      s0 = 2'b10;
      d0 = val[7:4];
      if (val[7:4] == 4'd0) begin
        s1 = 2'b00;
        d1 = 4'd0;
      end else begin
        s1 = 2'b10;
        d1 = val[7:4];
      end
    end else begin
      s0 = 2'b01;
      d0 = val[3:0];
      s1 = 2'b01;
      d1 = val[3:0];
    end
    n_cmp++;
    if ({u_if0.digit_sel, u_if0.digit_data} !== {s0, d0}) begin
      n_bad++;
      $display("FAIL %s k=%0d (nolz): got sel=%b data=%h, required sel=%b data=%h",
               name, k, u_if0.digit_sel, u_if0.digit_data, s0, d0);
    end
    n_cmp++;
    if ({u_if1.digit_sel, u_if1.digit_data} !== {s1, d1}) begin
      n_bad++;
      $display("FAIL %s k=%0d (blz): got sel=%b data=%h, required sel=%b data=%h",
               name, k, u_if1.digit_sel, u_if1.digit_data, s1, d1);
    end
  endtask

  initial begin
    // Vector table: inputs held for ncyc edges, then digits/wrap checked
    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{1'b1, 1'b1, 1'b0, 8'h00, 4,
                  {4'((i + 1) / 10), 4'((i + 1) % 10)}, 1'b0};
    end
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 2, 8'h10, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 6, 8'h10, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1, 8'h10, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1, 8'h11, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h5F, 1, 8'h59, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'hF0, 1, 8'h90, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h00, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 3, 8'h00, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h99, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h99, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 8'h30, 1, 8'h30, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 4, 8'h29, 1'b0};

    // Reset with a load pending: load must be ignored
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h57;
    tick(2);
    check_val("reset", 8'h00, 1'b0);
    check_scan("reset_scan", 0, 8'h00);
    rst = 1'b0; load = 1'b0; load_val = 8'h00;

    for (int i = 0; i < 22; i++) begin
      en = vecs[i].en; up = vecs[i].up; load = vecs[i].load; load_val = vecs[i].lv;
      tick(vecs[i].ncyc);
      check_val($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_wrap);
    end

    // Up wrap 99 -> 00 with a single-cycle wrap pulse
    en = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'h99;
    tick(1);
    check_val("wrapup_load", 8'h99, 1'b0);
    en = 1'b1; load = 1'b0;
    tick(3);
    check_val("wrapup_pre", 8'h99, 1'b0);
    tick(1);
    check_val("wrapup_step", 8'h00, 1'b1);
    tick(1);
    check_val("wrapup_after", 8'h00, 1'b0);

    // Load coincident with a step: load wins, clamps, restarts prescaler
    en = 1'b0; load = 1'b1; load_val = 8'h00;
    tick(1);
    en = 1'b1; load = 1'b0;
    tick(3);
    check_val("prio_pre", 8'h00, 1'b0);
    load = 1'b1; load_val = 8'hA3;
    tick(1);
    check_val("prio_load", 8'h93, 1'b0);
    load = 1'b0;
    tick(3);
    check_val("prio_hold", 8'h93, 1'b0);
    tick(1);
    check_val("prio_step", 8'h94, 1'b0);

    // Scan of value 42 from a fresh reset
    en = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_scan("scan42", 0, 8'h00);
    load = 1'b1; load_val = 8'h42;
    tick(1);
    load = 1'b0;
    check_scan("scan42", 1, 8'h42);
    for (int k = 2; k <= 9; k++) begin
      tick(1);
      check_scan("scan42", k, 8'h42);
    end

    // Value 07: tens slot blanked only in the blanking instance
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_scan("scan07", 0, 8'h00);
    load = 1'b1; load_val = 8'h07;
    tick(1);
    load = 1'b0;
    check_scan("scan07", 1, 8'h07);
    for (int k = 2; k <= 4; k++) begin
      tick(1);
      check_scan("scan07", k, 8'h07);
    end

    // Reset in the middle of the tens slot: ones slot restarts, full length
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_scan("midrst", 0, 8'h00);
    check_val("midrst_val", 8'h00, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check_scan("midrst", k, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd2_count_mux.md
Name: bcd2_count_mux

Overview:
- Two-digit BCD counter (00-99) with a time-multiplexed display feed for a two-digit 7-segment display.
- Sits directly upstream of the BCD-to-7-segment decoder.
- Drives one 4-bit BCD digit at a time to the decoder's data input, plus a one-hot digit select for the common lines.
- Handles count-step timing, up/down counting, parallel load, wrap detection, refresh scanning and optional leading-zero blanking.

Parameters:
- TICK_DIV, 50000000: clock cycles per count step; legal range >=1.
- REFRESH_DIV, 50000: clock cycles per digit display slot; legal range >=1.
- BLANK_LZ, 0: 1 = suppress the tens digit when it is 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; low freezes the counter and the step prescaler.
- up  input  1  count direction; 1 = up, 0 = down; sampled on each step.
- load  input  1  parallel load strobe.
- load_val  input  8  [7:4] = tens BCD, [3:0] = ones BCD.
- tens  output  4  registered tens digit, 0-9.
- ones  output  4  registered ones digit, 0-9.
- wrap  output  1  one-cycle pulse on a 99->00 (up) or 00->99 (down) step.
- digit_data  output  4  BCD digit currently selected; feeds the decoder input.
- digit_sel  output  2  one-hot, active-high digit enable; bit0 = ones, bit1 = tens.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of other inputs:
  - tens=0, ones=0, wrap=0.
  - Step prescaler=0, refresh prescaler=0.
  - Scan slot=ones, so digit_sel=2'b01 and digit_data=0.
- Step prescaler:
  - Counts 0..TICK_DIV-1 only while en=1.
  - Step pulse is generated internally on the cycle it equals TICK_DIV-1; it then returns to 0.
  - en=0 holds both the prescaler and the digits.
- Count step, registered; the new value is visible the cycle after the step cycle:
  - Up: ones 9->0 with tens+1; 99->00 with wrap=1.
  - Down: ones 0->9 with tens-1; 00->99 with wrap=1.
  - wrap is high for exactly one cycle, coincident with the new digit values.
- Load has priority over a step in the same cycle:
  - Next cycle: tens=load_val[7:4], ones=load_val[3:0], step prescaler=0, wrap=0.
  - Any load nibble >9 is stored as 9.
  - Load is honoured even when en=0.
- Digits never leave 0-9 under any input sequence.
- Refresh prescaler:
  - Free-running and independent of en and load; counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 the scan slot toggles (ones <-> tens).
  - Each slot therefore lasts exactly REFRESH_DIV cycles.
- Display outputs:
  - digit_data = ones in the ones slot, tens in the tens slot.
  - Combinational from registered state, so there is no extra latency versus tens/ones.
  - digit_sel = 2'b01 in the ones slot, 2'b10 in the tens slot.
  - With BLANK_LZ=1 and tens==0, the tens slot drives digit_sel=2'b00 and digit_data=0; the ones digit is never blanked.
  - digit_sel is never 2'b11.
- Reset mid-count or mid-slot: the next cycle is the full reset state; a pending step or load is discarded.

Test Plan:
- Reset: rst=1 for 2 cycles with load=1 and load_val=8'h57 -> tens=0, ones=0, digit_sel=01, digit_data=0, wrap=0.
- Step count (TICK_DIV=4, en=1, up=1, from 00):
  - ones increments every 4 cycles: 1, 2 ... 9, then 10.
  - Drop en for 6 cycles -> value and phase frozen; on resume the next step arrives after the remaining prescaler count.
- Wrap, up: load 8'h99, then one step up -> 00 with wrap high exactly 1 cycle.
- Wrap, down: load 8'h00, up=0, one step -> 99 with wrap=1.
- Load priority and clamping: load=1 in the same cycle as a step with load_val=8'hA3 -> result 93, no step applied, next step arrives 4 cycles later.
- Scan (REFRESH_DIV=3, value 42):
  - digit_sel alternates 01/10 every 3 cycles; digit_data 2/4 in step.
  - With BLANK_LZ=1 and value 07: the tens slot shows digit_sel=00, the ones slot shows 7.
  - Reset asserted mid-slot -> slot=ones with a full 3 cycles.
